// File: rtl/uart_ctrl.sv
// uart_ctrl: MEM-stage serial-port controller. It sends or receives one byte
// per access through the external UART's wrn/rdn strobes on the shared
// Ram1Data bus, stalls the pipeline for the duration of the access and
// exposes a status word that software can poll.
`timescale 1ns/1ps
module uart_ctrl #(
    parameter logic [15:0] DATA_ADDR     = 16'hBF00,
    parameter logic [15:0] STAT_ADDR     = 16'hBF01,
    parameter int unsigned WR_LOW_CYCLES = 2,
    parameter int unsigned RD_LOW_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic        isread_i,
    input  logic        iswrite_i,
    output logic [15:0] rdata_o,
    output logic        stall_o,
    output logic [15:0] bus_dout_o,
    output logic        bus_oe_o,
    input  logic [15:0] bus_din_i,
    output logic        ram1_dis_o,
    output logic        wrn_o,
    output logic        rdn_o,
    input  logic        data_ready_i,
    input  logic        tbre_i,
    input  logic        tsre_i
);

    localparam int unsigned LOW_MAX = (WR_LOW_CYCLES > RD_LOW_CYCLES) ? WR_LOW_CYCLES : RD_LOW_CYCLES;
    localparam int unsigned CNT_MAX = (LOW_MAX > SETTLE_CYCLES) ? LOW_MAX : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_SETUP = 3'd1,
        WR_PULSE = 3'd2,
        WR_HOLD  = 3'd3,
        WR_DONE  = 3'd4,
        RD_PULSE = 3'd5,
        RD_DONE  = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   ph_cnt_q;
    logic [CNT_W-1:0]   ph_cnt_d;
    logic [CNT_W-1:0]   settle_q;
    logic               tx_busy_q;
    logic [15:0]        rdata_q;

    logic [1:0]         dr_sync;
    logic [1:0]         tbre_sync;
    logic [1:0]         tsre_sync;
    logic               dr_s;
    logic               tbre_s;
    logic               tsre_s;
    logic               tx_ready;

    logic               data_req;
    logic               stat_rd;
    logic               load_byte;
    logic               capture;
    logic               wrn_d;
    logic               rdn_d;
    logic               oe_d;
    logic               dis_d;

    // Upper halves of the data paths are not used by the byte-wide UART.
    logic               unused_bits;
    assign unused_bits = ^{wdata_i[15:8], bus_din_i[15:8]};

    // Two-flop synchronisers for the asynchronous UART status pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dr_sync   <= 2'b00;
            tbre_sync <= 2'b00;
            tsre_sync <= 2'b00;
        end else begin
            dr_sync   <= {dr_sync[0],   data_ready_i};
            tbre_sync <= {tbre_sync[0], tbre_i};
            tsre_sync <= {tsre_sync[0], tsre_i};
        end
    end

    assign dr_s     = dr_sync[1];
    assign tbre_s   = tbre_sync[1];
    assign tsre_s   = tsre_sync[1];
    assign tx_ready = tbre_s & tsre_s & ~tx_busy_q;

    // Request decode; status reads are served only from IDLE.
    assign data_req = sel_i & (addr_i == DATA_ADDR) & (isread_i | iswrite_i);
    assign stat_rd  = sel_i & isread_i & (addr_i == STAT_ADDR) & (state_q == IDLE);

    // Status word while a status read is presented, otherwise the last data byte read.
    assign rdata_o = stat_rd ? {14'b0, dr_s, tx_ready} : rdata_q;

    // Next-state, stall and next-value decode of the registered bus/strobe outputs.
    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q;
        stall_o   = 1'b0;
        load_byte = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req) begin
                    stall_o = 1'b1;
                    if (iswrite_i) begin
                        // A write waits here while the previous byte is still in flight.
                        if (!tx_busy_q) begin
                            state_d   = WR_SETUP;
                            load_byte = 1'b1;
                        end
                    end else begin
                        state_d  = RD_PULSE;
                        ph_cnt_d = '0;
                    end
                end
            end
            WR_SETUP: begin
                stall_o  = 1'b1;
                state_d  = WR_PULSE;
                ph_cnt_d = '0;
            end
            WR_PULSE: begin
                stall_o = 1'b1;
                if (ph_cnt_q == CNT_W'(WR_LOW_CYCLES - 1)) begin
                    state_d = WR_HOLD;
                end else begin
                    ph_cnt_d = ph_cnt_q + CNT_W'(1);
                end
            end
            WR_HOLD: begin
                stall_o = 1'b1;
                state_d = WR_DONE;
            end
            WR_DONE: begin
                state_d = IDLE;
            end
            RD_PULSE: begin
                stall_o = 1'b1;
                if (ph_cnt_q == CNT_W'(RD_LOW_CYCLES - 1)) begin
                    state_d = RD_DONE;
                    capture = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt_q + CNT_W'(1);
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes and bus enables follow the state being entered, so they come out of flops.
        wrn_d = (state_d != WR_PULSE);
        rdn_d = (state_d != RD_PULSE);
        oe_d  = (state_d == WR_SETUP) | (state_d == WR_PULSE) | (state_d == WR_HOLD);
        dis_d = oe_d | (state_d == RD_PULSE);
    end

    // State, phase counter and registered interface outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ph_cnt_q   <= '0;
            wrn_o      <= 1'b1;
            rdn_o      <= 1'b1;
            bus_oe_o   <= 1'b0;
            ram1_dis_o <= 1'b0;
            bus_dout_o <= 16'h0000;
            rdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            wrn_o      <= wrn_d;
            rdn_o      <= rdn_d;
            bus_oe_o   <= oe_d;
            ram1_dis_o <= dis_d;
            if (load_byte) begin
                bus_dout_o <= {8'h00, wdata_i[7:0]};
            end
            if (capture) begin
                rdata_q <= {8'h00, bus_din_i[7:0]};
            end
        end
    end

    // Transmit-busy tracking: hold off the next write until the UART has
    // settled after the strobe and reports both buffers empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_busy_q <= 1'b0;
            settle_q  <= '0;
        end else if (state_q == WR_HOLD) begin
            tx_busy_q <= 1'b1;
            settle_q  <= '0;
        end else if (tx_busy_q) begin
            if ((settle_q == CNT_W'(SETTLE_CYCLES)) && tbre_s && tsre_s) begin
                tx_busy_q <= 1'b0;
            end else if (settle_q != CNT_W'(SETTLE_CYCLES)) begin
                settle_q <= settle_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed testbench for uart_ctrl: reset, write/read sequences, status
// polling, write-after-write holdoff and reset during a write strobe.
`timescale 1ns/1ps
module tb_uart_ctrl;

    logic        clk;
    logic        rst;
    logic        sel_i;
    logic [15:0] addr_i;
    logic [15:0] wdata_i;
    logic        isread_i;
    logic        iswrite_i;
    logic [15:0] rdata_o;
    logic        stall_o;
    logic [15:0] bus_dout_o;
    logic        bus_oe_o;
    logic [15:0] bus_din_i;
    logic        ram1_dis_o;
    logic        wrn_o;
    logic        rdn_o;
    logic        data_ready_i;
    logic        tbre_i;
    logic        tsre_i;

    int n_chk  = 0;
    int n_fail = 0;

    uart_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sel_i        (sel_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .isread_i     (isread_i),
        .iswrite_i    (iswrite_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .bus_dout_o   (bus_dout_o),
        .bus_oe_o     (bus_oe_o),
        .bus_din_i    (bus_din_i),
        .ram1_dis_o   (ram1_dis_o),
        .wrn_o        (wrn_o),
        .rdn_o        (rdn_o),
        .data_ready_i (data_ready_i),
        .tbre_i       (tbre_i),
        .tsre_i       (tsre_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    // Full write to the data register, checked cycle by cycle from the
    // request cycle through WR_DONE; returns at the start of the following cycle.
    task automatic write_seq(input logic [15:0] wd, input logic rd_too, input logic drop_tsre);
        logic [5:0] e_stall;
        logic [5:0] e_wrn;
        logic [5:0] e_oe;
        e_stall = 6'b011111;
        e_wrn   = 6'b110011;
        e_oe    = 6'b011110;
        sel_i     = 1'b1;
        addr_i    = 16'hBF00;
        iswrite_i = 1'b1;
        isread_i  = rd_too;
        wdata_i   = wd;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1($sformatf("wr_stall_c%0d", i), stall_o, e_stall[i]);
            chk1($sformatf("wr_wrn_c%0d", i), wrn_o, e_wrn[i]);
            chk1($sformatf("wr_oe_c%0d", i), bus_oe_o, e_oe[i]);
            chk1($sformatf("wr_rdn_c%0d", i), rdn_o, 1'b1);
            if (i >= 1 && i <= 4) begin
                chk($sformatf("wr_dout_c%0d", i), bus_dout_o, {8'h00, wd[7:0]});
                chk1($sformatf("wr_dis_c%0d", i), ram1_dis_o, 1'b1);
            end
            if (i == 5) begin
                chk1("wr_dis_done", ram1_dis_o, 1'b0);
            end
            next_cycle();
            if (i == 4 && drop_tsre) begin
                tsre_i = 1'b0;
            end
            if (i == 5) begin
                sel_i     = 1'b0;
                iswrite_i = 1'b0;
                isread_i  = 1'b0;
            end
        end
    endtask

    initial begin
        int cyc;
        int first_low;
        logic early_release;

        rst          = 1'b0;
        sel_i        = 1'b0;
        addr_i       = 16'h0000;
        wdata_i      = 16'h0000;
        isread_i     = 1'b0;
        iswrite_i    = 1'b0;
        bus_din_i    = 16'h0000;
        data_ready_i = 1'b1;
        tbre_i       = 1'b1;
        tsre_i       = 1'b1;

        // Reset state
        idle(3);
        @(negedge clk);
        chk1("rst_wrn", wrn_o, 1'b1);
        chk1("rst_rdn", rdn_o, 1'b1);
        chk1("rst_oe", bus_oe_o, 1'b0);
        chk1("rst_dis", ram1_dis_o, 1'b0);
        chk("rst_dout", bus_dout_o, 16'h0000);
        chk("rst_rdata", rdata_o, 16'h0000);
        chk1("rst_stall", stall_o, 1'b0);
        next_cycle();
        rst = 1'b1;
        idle(3);

        // Status read while idle: data ready and transmitter ready
        sel_i    = 1'b1;
        addr_i   = 16'hBF01;
        isread_i = 1'b1;
        @(negedge clk);
        chk("stat_idle", rdata_o, 16'h0003);
        chk1("stat_idle_stall", stall_o, 1'b0);
        next_cycle();
        sel_i = 1'b0;
        @(negedge clk);
        chk("stat_unselected", rdata_o, 16'h0000);
        next_cycle();
        isread_i = 1'b0;

        // Write 0x1241: only the low byte is transmitted
        write_seq(16'h1241, 1'b0, 1'b0);

        // Status read right after the write: transmitter busy until settle elapses
        sel_i    = 1'b1;
        addr_i   = 16'hBF01;
        isread_i = 1'b1;
        @(negedge clk);
        chk("stat_busy_c6", rdata_o, 16'h0002);
        chk1("stat_busy_stall", stall_o, 1'b0);
        idle(3);
        @(negedge clk);
        chk("stat_busy_c9", rdata_o, 16'h0002);
        next_cycle();
        @(negedge clk);
        chk("stat_free_c10", rdata_o, 16'h0003);
        next_cycle();
        sel_i    = 1'b0;
        isread_i = 1'b0;

        // Write to the status register is ignored
        sel_i     = 1'b1;
        addr_i    = 16'hBF01;
        iswrite_i = 1'b1;
        wdata_i   = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1($sformatf("statwr_stall_%0d", i), stall_o, 1'b0);
            chk1($sformatf("statwr_wrn_%0d", i), wrn_o, 1'b1);
            chk1($sformatf("statwr_oe_%0d", i), bus_oe_o, 1'b0);
            next_cycle();
        end
        sel_i     = 1'b0;
        iswrite_i = 1'b0;

        // Data read with 0xFF5A on the bus
        bus_din_i = 16'hFF5A;
        sel_i     = 1'b1;
        addr_i    = 16'hBF00;
        isread_i  = 1'b1;
        @(negedge clk);
        chk1("rd_stall_r0", stall_o, 1'b1);
        chk1("rd_rdn_r0", rdn_o, 1'b1);
        next_cycle();
        @(negedge clk);
        chk1("rd_stall_r1", stall_o, 1'b1);
        chk1("rd_rdn_r1", rdn_o, 1'b0);
        chk1("rd_dis_r1", ram1_dis_o, 1'b1);
        chk1("rd_oe_r1", bus_oe_o, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rd_stall_r2", stall_o, 1'b1);
        chk1("rd_rdn_r2", rdn_o, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rd_stall_r3", stall_o, 1'b0);
        chk1("rd_rdn_r3", rdn_o, 1'b1);
        chk("rd_rdata_r3", rdata_o, 16'h005A);
        next_cycle();
        sel_i     = 1'b0;
        isread_i  = 1'b0;
        bus_din_i = 16'h0000;
        @(negedge clk);
        chk("rd_rdata_hold", rdata_o, 16'h005A);
        chk1("rd_rdn_idle", rdn_o, 1'b1);
        next_cycle();

        // Read and write together at the data address: the write wins
        write_seq(16'h0033, 1'b1, 1'b0);
        chk("rw_rdata_kept", rdata_o, 16'h005A);
        idle(8);

        // Back-to-back writes with tsre low for 20 cycles after the first
        write_seq(16'h0041, 1'b0, 1'b1);
        sel_i     = 1'b1;
        addr_i    = 16'hBF00;
        iswrite_i = 1'b1;
        wdata_i   = 16'h0042;
        cyc           = 6;
        first_low     = -1;
        early_release = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (wrn_o == 1'b0) begin
                first_low = cyc;
                break;
            end
            if (stall_o == 1'b0) begin
                early_release = 1'b1;
            end
            next_cycle();
            cyc++;
            if (cyc == 25) begin
                tsre_i = 1'b1;
            end
        end
        chk("b2b_first_low_cycle", 16'(first_low), 16'd30);
        chk1("b2b_stall_held", early_release, 1'b0);
        chk("b2b_dout", bus_dout_o, 16'h0042);
        chk1("b2b_stall_pulse", stall_o, 1'b1);
        next_cycle();
        @(negedge clk);
        chk1("b2b_wrn_c31", wrn_o, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("b2b_wrn_c32", wrn_o, 1'b1);
        chk1("b2b_stall_c32", stall_o, 1'b1);
        next_cycle();
        @(negedge clk);
        chk1("b2b_stall_c33", stall_o, 1'b0);
        next_cycle();
        sel_i     = 1'b0;
        iswrite_i = 1'b0;
        idle(10);

        // Reset asserted for two cycles during the write strobe
        sel_i     = 1'b1;
        addr_i    = 16'hBF00;
        iswrite_i = 1'b1;
        wdata_i   = 16'h0055;
        idle(2);
        rst       = 1'b0;
        sel_i     = 1'b0;
        iswrite_i = 1'b0;
        @(negedge clk);
        chk1("mid_rst_wrn_pulse", wrn_o, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("mid_rst_wrn", wrn_o, 1'b1);
        chk1("mid_rst_oe", bus_oe_o, 1'b0);
        chk1("mid_rst_stall", stall_o, 1'b0);
        chk1("mid_rst_dis", ram1_dis_o, 1'b0);
        chk("mid_rst_dout", bus_dout_o, 16'h0000);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk1("post_rst_wrn", wrn_o, 1'b1);
        chk1("post_rst_stall", stall_o, 1'b0);
        idle(3);
        sel_i    = 1'b1;
        addr_i   = 16'hBF01;
        isread_i = 1'b1;
        @(negedge clk);
        chk("post_rst_stat", rdata_o, 16'h0003);
        chk1("post_rst_wrn_idle", wrn_o, 1'b1);
        next_cycle();
        sel_i    = 1'b0;
        isread_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- MEM-stage serial-port controller; consumes MEM-stage requests decoded as UART (is_UART) and drives the external UART chip's wrn/rdn handshake on the shared Ram1Data bus.
- Serialises one byte per access, stalls the pipeline for the duration and exposes a status word for software polling.
- Disables RAM1 while it owns the bus.

Parameters:
- DATA_ADDR, 16'hBF00, address of the UART data register.
- STAT_ADDR, 16'hBF01, address of the UART status register.
- WR_LOW_CYCLES, 2, number of cycles wrn_o is held low per write (>=1).
- RD_LOW_CYCLES, 2, number of cycles rdn_o is held low per read (>=1).
- SETTLE_CYCLES, 4, minimum number of cycles after the wrn rising edge before tx_busy may clear.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- sel_i  in  1  MEM stage targets the UART (is_UART)
- addr_i  in  16  MEM-stage address (ALU result)
- wdata_i  in  16  store data; only [7:0] is transmitted
- isread_i  in  1  load request
- iswrite_i  in  1  store request
- rdata_o  out  16  load result to MEM result mux
- stall_o  out  1  hold IF..EX/MEM registers
- bus_dout_o  out  16  value driven onto Ram1Data
- bus_oe_o  out  1  1 = drive Ram1Data, 0 = high-Z
- bus_din_i  in  16  Ram1Data as sampled
- ram1_dis_o  out  1  1 = force Ram1EN high (RAM1 off)
- wrn_o  out  1  UART write strobe, active low
- rdn_o  out  1  UART read strobe, active low
- data_ready_i  in  1  UART has a received byte (asynchronous)
- tbre_i  in  1  transmit buffer empty (asynchronous)
- tsre_i  in  1  transmit shift register empty (asynchronous)

Behaviour:
- Reset (rst=0 at posedge):
  - state IDLE; wrn_o=1, rdn_o=1, bus_oe_o=0, ram1_dis_o=0, bus_dout_o=0, rdata_o=0, tx_busy=0.
  - Synchronisers are cleared to 0.
  - Reset mid-transfer aborts the transfer in the same edge, with no further strobe.
- data_ready_i, tbre_i and tsre_i each pass through a 2-flop synchroniser to give dr_s, tbre_s and tsre_s.
- tx_ready = tbre_s & tsre_s & ~tx_busy.
- Status register:
  - Condition: sel_i & isread_i & addr_i==STAT_ADDR in IDLE.
  - rdata_o = {14'b0, dr_s, tx_ready}, combinational, no stall.
  - Writes to STAT_ADDR are ignored, with no stall.
- Data request: sel_i & addr_i==DATA_ADDR & (isread_i|iswrite_i) in IDLE.
  - stall_o rises combinationally in the same cycle.
  - If both isread_i and iswrite_i are set, the write wins.
- Write FSM:
  - IDLE: if tx_busy=1, remain in IDLE with stall_o=1 until tx_busy=0. Otherwise latch wdata_i[7:0] and go to WR_SETUP.
  - WR_SETUP (1 cycle): bus_oe_o=1, bus_dout_o={8'h00,byte}, ram1_dis_o=1, wrn_o=1.
  - WR_PULSE (WR_LOW_CYCLES cycles): wrn_o=0; bus_oe_o and bus_dout_o unchanged.
  - WR_HOLD (1 cycle): wrn_o=1, data still driven, tx_busy<=1, settle counter<=0.
  - WR_DONE (1 cycle): stall_o=0, bus_oe_o=0, ram1_dis_o=0; next state IDLE.
  - Stall length is 3+WR_LOW_CYCLES cycles when tx_busy=0.
- tx_busy:
  - The settle counter increments while tx_busy=1, saturating at SETTLE_CYCLES.
  - tx_busy clears when counter==SETTLE_CYCLES & tbre_s & tsre_s.
- Read FSM:
  - IDLE -> RD_PULSE (RD_LOW_CYCLES cycles): rdn_o=0, bus_oe_o=0, ram1_dis_o=1. bus_din_i[7:0] is captured at the posedge ending the last low cycle.
  - RD_DONE (1 cycle): rdn_o=1, stall_o=0, rdata_o={8'h00,byte}; next state IDLE.
  - Stall length is 1+RD_LOW_CYCLES cycles.
  - A read does not wait for data_ready; software polls the status register first.
- rdata_o holds its last data-read value until the next read completes. This does not apply while a status read is being presented.
- No new request is accepted in WR_DONE or RD_DONE. The pipeline advances in that cycle, and the next request is seen in IDLE.
- sel_i=0 or any other address in IDLE: no action, stall_o=0, strobes high.

Test Plan:
- Reset: rst=0 for 2 cycles during WR_PULSE -> next cycle wrn_o=1, bus_oe_o=0, stall_o=0, state IDLE.
- Write 16'h1241 to BF00, tbre/tsre=1 -> stall_o high for 5 cycles; wrn_o low for exactly 2 cycles with bus_dout_o=16'h0041 and bus_oe_o=1 from setup through hold.
- Back-to-back writes 'A','B' with tsre held low for 20 cycles after the first write -> second write stays stalled in IDLE; its wrn pulse starts only after tsre_s=1 and the settle count has elapsed.
- Status read at BF01: data_ready=1, tbre=tsre=1, idle -> after 2 cycles of sync rdata_o=16'h0003 with stall_o=0; immediately after a write -> 16'h0002 or 16'h0000 per dr_s.
- Data read at BF00 with bus_din_i=16'hFF5A -> rdn_o low 2 cycles; rdata_o=16'h005A in RD_DONE; stall_o high 3 cycles.
- isread_i=iswrite_i=1 at BF00 -> write sequence only, rdn_o never low; write to BF01 -> no strobe, no stall.
